// File: rtl/icache_pkg.sv
// Shared widths and state encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned INDEX_WIDTH  = 5;
    localparam int unsigned ADDR_WIDTH   = 18;
    localparam int unsigned LINE_WORDS   = 4;
    localparam int unsigned OFFSET_LSB   = 2;
    localparam int unsigned OFFSET_WIDTH = 2;
    localparam int unsigned INDEX_LSB    = 4;
    localparam int unsigned TAG_LSB      = INDEX_LSB + INDEX_WIDTH;
    localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - TAG_LSB;
    localparam int unsigned LINES        = 1 << INDEX_WIDTH;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    typedef logic [INDEX_WIDTH-1:0]  index_t;
    typedef logic [OFFSET_WIDTH-1:0] offset_t;
    typedef logic [TAG_WIDTH-1:0]    tag_t;
    typedef logic [XLEN-1:0]         word_t;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: one word-granular write port and a combinational lookup port.
module icache_line_store
    import icache_pkg::*;
(
    input  logic    clk_in,
    input  logic    rst_in,
    input  index_t  rd_index,
    input  offset_t rd_offset,
    input  tag_t    rd_tag,
    output logic    hit_c,
    output word_t   rd_data_c,
    input  index_t  wr_index,
    input  offset_t wr_offset,
    input  word_t   wr_data,
    input  tag_t    wr_tag,
    input  logic    word_we,
    input  logic    validate,
    input  logic    invalidate
);

    logic [LINES-1:0] valid_q;
    tag_t             tag_q  [LINES];
    word_t            data_q [LINES][LINE_WORDS];

    // Only the valid bits need a reset; tag/data are qualified by them.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (validate) begin
            valid_q[wr_index] <= 1'b1;
        end else if (invalidate) begin
            valid_q[wr_index] <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (validate) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    always_ff @(posedge clk_in) begin
        if (word_we) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

    assign hit_c     = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    assign rd_data_c = data_q[rd_index][rd_offset];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, 4-word line refill on miss.
module icache
    import icache_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        dec_en,
    input  logic [31:0] dec_addr,
    output logic        dec_rdy,
    output logic [31:0] dec_data,
    output logic        mc_en,
    output logic [31:0] mc_addr,
    input  logic        mc_rdy,
    input  logic [31:0] mc_data
);

    state_t  state, state_d;
    offset_t cnt, cnt_d;
    logic    mc_en_d, dec_rdy_d;
    word_t   mc_addr_d, dec_data_d;

    index_t  req_index, refill_index, wr_index;
    offset_t req_offset;
    tag_t    req_tag, refill_tag;
    word_t   req_base, rd_data;
    logic    hit, word_we, validate, invalidate;

    // Bits outside the cacheable range and the byte offset play no part.
    logic    unused_addr_bits;
    assign unused_addr_bits = ^{dec_addr[XLEN-1:ADDR_WIDTH], dec_addr[OFFSET_LSB-1:0]};

    assign req_offset   = dec_addr[OFFSET_LSB +: OFFSET_WIDTH];
    assign req_index    = dec_addr[INDEX_LSB +: INDEX_WIDTH];
    assign req_tag      = dec_addr[TAG_LSB +: TAG_WIDTH];
    assign req_base     = {{(XLEN-ADDR_WIDTH){1'b0}}, dec_addr[ADDR_WIDTH-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
    // The line under refill is identified by mc_addr itself.
    assign refill_index = mc_addr[INDEX_LSB +: INDEX_WIDTH];
    assign refill_tag   = mc_addr[TAG_LSB +: TAG_WIDTH];
    assign wr_index     = (state == REFILL) ? refill_index : req_index;

    icache_line_store u_store (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rd_index   (req_index),
        .rd_offset  (req_offset),
        .rd_tag     (req_tag),
        .hit_c      (hit),
        .rd_data_c  (rd_data),
        .wr_index   (wr_index),
        .wr_offset  (cnt),
        .wr_data    (mc_data),
        .wr_tag     (refill_tag),
        .word_we    (word_we),
        .validate   (validate),
        .invalidate (invalidate)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            cnt      <= '0;
            mc_en    <= 1'b0;
            mc_addr  <= '0;
            dec_rdy  <= 1'b0;
            dec_data <= '0;
        end else if (rdy_in) begin
            state    <= state_d;
            cnt      <= cnt_d;
            mc_en    <= mc_en_d;
            mc_addr  <= mc_addr_d;
            dec_rdy  <= dec_rdy_d;
            dec_data <= dec_data_d;
        end
    end

    // Next-state, register updates and array strobes; nothing moves while rdy_in is low.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        mc_en_d    = mc_en;
        mc_addr_d  = mc_addr;
        dec_rdy_d  = 1'b0;
        dec_data_d = dec_data;
        word_we    = 1'b0;
        validate   = 1'b0;
        invalidate = 1'b0;
        if (rdy_in && !rst_in) begin
            if (flush) begin
                state_d = IDLE;
                mc_en_d = 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        // dec_rdy high means this dec_en was just answered.
                        if (dec_en && !dec_rdy) begin
                            if (hit) begin
                                dec_rdy_d  = 1'b1;
                                dec_data_d = rd_data;
                            end else begin
                                invalidate = 1'b1;
                                cnt_d      = '0;
                                mc_en_d    = 1'b1;
                                mc_addr_d  = req_base;
                                state_d    = REFILL;
                            end
                        end
                    end
                    REFILL: begin
                        if (mc_rdy) begin
                            word_we = 1'b1;
                            if (cnt == OFFSET_WIDTH'(LINE_WORDS - 1)) begin
                                validate = 1'b1;
                                mc_en_d  = 1'b0;
                                state_d  = IDLE;
                            end else begin
                                cnt_d     = OFFSET_WIDTH'(cnt + 1'b1);
                                mc_addr_d = XLEN'(mc_addr + 32'd4);
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache with a hand-driven MemoryControl.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush = 1'b0;
    logic        dec_en = 1'b0;
    logic [31:0] dec_addr = '0;
    logic        dec_rdy;
    logic [31:0] dec_data;
    logic        mc_en;
    logic [31:0] mc_addr;
    logic        mc_rdy = 1'b0;
    logic [31:0] mc_data = '0;

    int checks = 0;
    int errors = 0;

    logic [127:0] addrs;
    logic         all_en;

    icache dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush    (flush),
        .dec_en   (dec_en),
        .dec_addr (dec_addr),
        .dec_rdy  (dec_rdy),
        .dec_data (dec_data),
        .mc_en    (mc_en),
        .mc_addr  (mc_addr),
        .mc_rdy   (mc_rdy),
        .mc_data  (mc_data)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA500_0000 ^ {a[15:0], a[15:0]};
    endfunction

    function automatic logic [127:0] seq(input logic [31:0] start, input int n);
        logic [127:0] s = '0;
        for (int i = 0; i < n; i++) s[32*i +: 32] = start + 32'(4 * i);
        return s;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_fetch(input logic [31:0] a);
        dec_en   = 1'b1;
        dec_addr = a;
        step();
    endtask

    // Serves n back-to-back words, recording each requested address.
    task automatic do_refill(input int n, output logic [127:0] seen, output logic en_ok);
        seen  = '0;
        en_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            seen[32*i +: 32] = mc_addr;
            en_ok   = en_ok & mc_en;
            mc_rdy  = 1'b1;
            mc_data = mem_word(mc_addr);
            step();
            mc_rdy  = 1'b0;
        end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (dec_rdy !== 1'b0) begin errors++; $display("FAIL reset_dec_rdy got %b exp 0", dec_rdy); end
        checks++; if (dec_data !== 32'h0) begin errors++; $display("FAIL reset_dec_data got %h exp 0", dec_data); end
        checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL reset_mc_en got %b exp 0", mc_en); end
        checks++; if (mc_addr !== 32'h0) begin errors++; $display("FAIL reset_mc_addr got %h exp 0", mc_addr); end
        rst_in = 1'b0;
        step();
    endtask

    task automatic test_cold_miss();
        start_fetch(32'h0);
        do_refill(4, addrs, all_en);
        checks++; if (addrs !== seq(32'h0, 4)) begin errors++; $display("FAIL cold_addrs got %h exp %h", addrs, seq(32'h0, 4)); end
        checks++; if (all_en !== 1'b1) begin errors++; $display("FAIL cold_mc_en_continuous got %b exp 1", all_en); end
        checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL cold_mc_en_drop got %b exp 0", mc_en); end
        checks++; if (dec_rdy !== 1'b0) begin errors++; $display("FAIL cold_rdy_early got %b exp 0", dec_rdy); end
        step();
        checks++; if (dec_rdy !== 1'b1) begin errors++; $display("FAIL cold_rdy got %b exp 1", dec_rdy); end
        checks++; if (dec_data !== mem_word(32'h0)) begin errors++; $display("FAIL cold_data got %h exp %h", dec_data, mem_word(32'h0)); end
        dec_en = 1'b0;
        step();
        start_fetch(32'h8);
        checks++; if (dec_rdy !== 1'b1) begin errors++; $display("FAIL hit8_rdy got %b exp 1", dec_rdy); end
        checks++; if (dec_data !== mem_word(32'h8)) begin errors++; $display("FAIL hit8_data got %h exp %h", dec_data, mem_word(32'h8)); end
        checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL hit8_mc_en got %b exp 0", mc_en); end
        dec_en = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        start_fetch(32'h4);
        checks++; if (dec_data !== mem_word(32'h4)) begin errors++; $display("FAIL b2b_first_data got %h exp %h", dec_data, mem_word(32'h4)); end
        dec_addr = 32'hC;
        step();
        checks++; if (dec_rdy !== 1'b0) begin errors++; $display("FAIL b2b_bubble got %b exp 0", dec_rdy); end
        step();
        checks++; if (dec_rdy !== 1'b1) begin errors++; $display("FAIL b2b_second_rdy got %b exp 1", dec_rdy); end
        checks++; if (dec_data !== mem_word(32'hC)) begin errors++; $display("FAIL b2b_second_data got %h exp %h", dec_data, mem_word(32'hC)); end
        dec_en = 1'b0;
        step();
    endtask

    task automatic test_conflict();
        start_fetch(32'h200);
        do_refill(4, addrs, all_en);
        checks++; if (addrs !== seq(32'h200, 4)) begin errors++; $display("FAIL conflict_addrs got %h exp %h", addrs, seq(32'h200, 4)); end
        step();
        checks++; if (dec_data !== mem_word(32'h200)) begin errors++; $display("FAIL conflict_data got %h exp %h", dec_data, mem_word(32'h200)); end
        dec_en = 1'b0;
        step();
        start_fetch(32'h0);
        checks++; if (mc_en !== 1'b1) begin errors++; $display("FAIL refetch0_miss got %b exp 1", mc_en); end
        do_refill(4, addrs, all_en);
        checks++; if (addrs !== seq(32'h0, 4)) begin errors++; $display("FAIL refetch0_addrs got %h exp %h", addrs, seq(32'h0, 4)); end
        step();
        checks++; if (dec_data !== mem_word(32'h0)) begin errors++; $display("FAIL refetch0_data got %h exp %h", dec_data, mem_word(32'h0)); end
        dec_en = 1'b0;
        step();
    endtask

    task automatic test_flush_mid();
        start_fetch(32'h204);
        do_refill(2, addrs, all_en);
        flush = 1'b1;
        step();
        flush  = 1'b0;
        dec_en = 1'b0;
        checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL flushmid_mc_en got %b exp 0", mc_en); end
        checks++; if (dec_rdy !== 1'b0) begin errors++; $display("FAIL flushmid_rdy got %b exp 0", dec_rdy); end
        step();
        checks++; if (dec_rdy !== 1'b0 || mc_en !== 1'b0) begin errors++; $display("FAIL flushmid_idle got rdy %b en %b exp 0 0", dec_rdy, mc_en); end
        start_fetch(32'h4);
        do_refill(4, addrs, all_en);
        checks++; if (addrs !== seq(32'h0, 4)) begin errors++; $display("FAIL flushmid_refetch got %h exp %h", addrs, seq(32'h0, 4)); end
        step();
        checks++; if (dec_data !== mem_word(32'h4)) begin errors++; $display("FAIL flushmid_data got %h exp %h", dec_data, mem_word(32'h4)); end
        dec_en = 1'b0;
        step();
    endtask

    task automatic test_flush_final();
        start_fetch(32'h30);
        do_refill(3, addrs, all_en);
        mc_rdy  = 1'b1;
        mc_data = mem_word(mc_addr);
        flush   = 1'b1;
        step();
        mc_rdy = 1'b0;
        flush  = 1'b0;
        dec_en = 1'b0;
        checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL flushfin_mc_en got %b exp 0", mc_en); end
        step();
        checks++; if (dec_rdy !== 1'b0) begin errors++; $display("FAIL flushfin_rdy got %b exp 0", dec_rdy); end
        start_fetch(32'h30);
        checks++; if (mc_en !== 1'b1 || mc_addr !== 32'h30) begin errors++; $display("FAIL flushfin_remiss got en %b addr %h exp 1 00000030", mc_en, mc_addr); end
        do_refill(4, addrs, all_en);
        step();
        checks++; if (dec_data !== mem_word(32'h30)) begin errors++; $display("FAIL flushfin_data got %h exp %h", dec_data, mem_word(32'h30)); end
        dec_en = 1'b0;
        step();
    endtask

    task automatic test_stall();
        start_fetch(32'h50);
        do_refill(1, addrs, all_en);
        rdy_in  = 1'b0;
        mc_rdy  = 1'b1;
        mc_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (mc_addr !== 32'h54 || mc_en !== 1'b1) begin errors++; $display("FAIL stall_refill got en %b addr %h exp 1 00000054", mc_en, mc_addr); end
        end
        rdy_in = 1'b1;
        mc_rdy = 1'b0;
        do_refill(3, addrs, all_en);
        checks++; if (addrs !== seq(32'h54, 3)) begin errors++; $display("FAIL stall_resume got %h exp %h", addrs, seq(32'h54, 3)); end
        step();
        checks++; if (dec_data !== mem_word(32'h50)) begin errors++; $display("FAIL stall_data got %h exp %h", dec_data, mem_word(32'h50)); end
        dec_en = 1'b0;
        step();
        start_fetch(32'h54);
        rdy_in = 1'b0;
        dec_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (dec_rdy !== 1'b1 || dec_data !== mem_word(32'h54)) begin errors++; $display("FAIL stall_hit got %b %h exp 1 %h", dec_rdy, dec_data, mem_word(32'h54)); end
        end
        rdy_in = 1'b1;
        step();
        checks++; if (dec_rdy !== 1'b0) begin errors++; $display("FAIL stall_hit_release got %b exp 0", dec_rdy); end
    endtask

    task automatic test_reset_mid();
        start_fetch(32'h100);
        do_refill(4, addrs, all_en);
        step();
        checks++; if (dec_data !== mem_word(32'h100)) begin errors++; $display("FAIL rst_fill_data got %h exp %h", dec_data, mem_word(32'h100)); end
        dec_en = 1'b0;
        step();
        start_fetch(32'h60);
        do_refill(2, addrs, all_en);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        dec_en = 1'b0;
        checks++; if (mc_en !== 1'b0 || dec_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got en %b rdy %b exp 0 0", mc_en, dec_rdy); end
        step();
        start_fetch(32'h100);
        checks++; if (mc_en !== 1'b1 || mc_addr !== 32'h100) begin errors++; $display("FAIL rstmid_remiss got en %b addr %h exp 1 00000100", mc_en, mc_addr); end
        do_refill(4, addrs, all_en);
        step();
        checks++; if (dec_rdy !== 1'b1 || dec_data !== mem_word(32'h100)) begin errors++; $display("FAIL rstmid_data got %b %h exp 1 %h", dec_rdy, dec_data, mem_word(32'h100)); end
        dec_en = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_flush_mid();
        test_flush_final();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
